// File: rtl/mem_stage.sv
// Memory-access stage: word-organised data memory, taken-branch resolution
// for fetch, illegal-access detection with a sticky flag, and the MEM/WB
// pipeline register feeding write-back.
module mem_stage #(
  parameter int DEPTH_WORDS = 128
) (
  input  logic        clk_i,
  input  logic        rst_n,
  input  logic [4:0]  decoder_i,
  input  logic [31:0] branch_target_i,
  input  logic        zero_i,
  input  logic [31:0] alu_result_i,
  input  logic [31:0] write_data_i,
  input  logic [4:0]  write_reg_i,
  input  logic        stall_i,
  output logic        pc_src_o,
  output logic [31:0] branch_target_o,
  output logic        reg_write_o,
  output logic        mem_to_reg_o,
  output logic [31:0] read_data_o,
  output logic [31:0] alu_result_o,
  output logic [4:0]  write_reg_o,
  output logic        access_err_o
);

  localparam int AW = $clog2(DEPTH_WORDS);

  // Decoder field positions.
  localparam int D_REG_WRITE  = 4;
  localparam int D_MEM_TO_REG = 3;
  localparam int D_BRANCH     = 2;
  localparam int D_MEM_READ   = 1;
  localparam int D_MEM_WRITE  = 0;

  logic [31:0]   mem [DEPTH_WORDS];

  logic [AW-1:0] word_idx;
  logic          misaligned;
  logic          out_of_range;
  logic          mem_access;
  logic          illegal;
  logic          mem_we;
  logic [31:0]   rd_word;
  logic [31:0]   load_data;

  // MEM/WB pipeline register fields.
  logic          reg_write_p1;
  logic          mem_to_reg_p1;
  logic [31:0]   read_data_p1;
  logic [31:0]   alu_result_p1;
  logic [4:0]    write_reg_p1;
  logic          access_err_p1;

  // ---- Stage p0: address decode, branch resolution, asynchronous read ----

  // Addresses above the memory are flagged rather than aliased onto it.
  always_comb begin
    word_idx     = alu_result_i[AW+1:2];
    misaligned   = |alu_result_i[1:0];
    out_of_range = |alu_result_i[31:AW+2];
    mem_access   = decoder_i[D_MEM_READ] | decoder_i[D_MEM_WRITE];
    illegal      = mem_access & (misaligned | out_of_range);
    // A low rst_n at the edge must also cancel an in-flight store.
    mem_we       = decoder_i[D_MEM_WRITE] & ~illegal & ~stall_i & rst_n;
    rd_word      = mem[word_idx];
    load_data    = (decoder_i[D_MEM_READ] & ~illegal) ? rd_word : 32'h0;
  end

  // Branch decision goes straight to fetch; a stall does not gate it.
  assign pc_src_o        = decoder_i[D_BRANCH] & zero_i;
  assign branch_target_o = branch_target_i;

  // Data memory write port; contents are deliberately left out of reset.
  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      mem[word_idx] <= write_data_i;
    end
  end

  // ---- Stage p1: MEM/WB register ----

  // Capture the instruction's write-back fields unless the pipe is stalled.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      reg_write_p1  <= 1'b0;
      mem_to_reg_p1 <= 1'b0;
      read_data_p1  <= 32'h0;
      alu_result_p1 <= 32'h0;
      write_reg_p1  <= 5'd0;
    end else if (!stall_i) begin
      reg_write_p1  <= decoder_i[D_REG_WRITE];
      mem_to_reg_p1 <= decoder_i[D_MEM_TO_REG];
      read_data_p1  <= load_data;
      alu_result_p1 <= alu_result_i;
      write_reg_p1  <= write_reg_i;
    end
  end

  // Sticky error flag: set by any non-stalled illegal access, cleared only by reset.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      access_err_p1 <= 1'b0;
    end else if (illegal && !stall_i) begin
      access_err_p1 <= 1'b1;
    end
  end

  assign reg_write_o  = reg_write_p1;
  assign mem_to_reg_o = mem_to_reg_p1;
  assign read_data_o  = read_data_p1;
  assign alu_result_o = alu_result_p1;
  assign write_reg_o  = write_reg_p1;
  assign access_err_o = access_err_p1;

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed scenarios plus randomized traffic, checked by
// a scoreboard fed from a behavioural model of memory and the MEM/WB fields.
module tb_mem_stage;

  localparam int DEPTH = 128;

  logic        clk_i = 1'b0;
  logic        rst_n = 1'b1;
  logic [4:0]  decoder_i = 5'd0;
  logic [31:0] branch_target_i = 32'h0;
  logic        zero_i = 1'b0;
  logic [31:0] alu_result_i = 32'h0;
  logic [31:0] write_data_i = 32'h0;
  logic [4:0]  write_reg_i = 5'd0;
  logic        stall_i = 1'b1;
  logic        pc_src_o;
  logic [31:0] branch_target_o;
  logic        reg_write_o;
  logic        mem_to_reg_o;
  logic [31:0] read_data_o;
  logic [31:0] alu_result_o;
  logic [4:0]  write_reg_o;
  logic        access_err_o;

  mem_stage #(.DEPTH_WORDS(DEPTH)) dut (
    .clk_i           (clk_i),
    .rst_n           (rst_n),
    .decoder_i       (decoder_i),
    .branch_target_i (branch_target_i),
    .zero_i          (zero_i),
    .alu_result_i    (alu_result_i),
    .write_data_i    (write_data_i),
    .write_reg_i     (write_reg_i),
    .stall_i         (stall_i),
    .pc_src_o        (pc_src_o),
    .branch_target_o (branch_target_o),
    .reg_write_o     (reg_write_o),
    .mem_to_reg_o    (mem_to_reg_o),
    .read_data_o     (read_data_o),
    .alu_result_o    (alu_result_o),
    .write_reg_o     (write_reg_o),
    .access_err_o    (access_err_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        rw;
    logic        m2r;
    logic [31:0] rd;
    logic [31:0] alu;
    logic [4:0]  wr;
    logic        err;
    bit          rd_care;
  } exp_t;

  int   total = 0;
  int   bad   = 0;
  bit   mon_en = 1'b0;
  exp_t q[$];
  exp_t m_wb;
  exp_t mon_e;

  // Reference memory: plain array of words plus a "has been written" mark.
  int unsigned m_mem   [DEPTH];
  bit          m_known [DEPTH];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  // Present one instruction for one cycle and predict the MEM/WB state after the edge.
  task automatic issue(input logic [4:0] dec, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [4:0] wreg, input logic zero, input logic [31:0] btgt,
                       input logic stall);
    int idx;
    bit is_rd, is_wr, illegal;
    @(negedge clk_i);
    decoder_i       = dec;
    alu_result_i    = addr;
    write_data_i    = wdata;
    write_reg_i     = wreg;
    zero_i          = zero;
    branch_target_i = btgt;
    stall_i         = stall;
    is_rd   = dec[1];
    is_wr   = dec[0];
    idx     = int'((addr / 4) % DEPTH);
    illegal = (is_rd || is_wr) && ((addr % 4) != 0 || addr >= 32'(DEPTH * 4));
    if (!stall) begin
      m_wb.rw  = dec[4];
      m_wb.m2r = dec[3];
      m_wb.alu = addr;
      m_wb.wr  = wreg;
      if (is_rd && !illegal) begin
        m_wb.rd      = m_mem[idx];
        m_wb.rd_care = m_known[idx];
      end else begin
        m_wb.rd      = 32'h0;
        m_wb.rd_care = 1'b1;
      end
      if (illegal) m_wb.err = 1'b1;
      if (is_wr && !illegal) begin
        m_mem[idx]   = wdata;
        m_known[idx] = 1'b1;
      end
    end
    q.push_back(m_wb);
    mon_en = 1'b1;
    #1;
    chk("pc_src", 32'(pc_src_o), 32'(dec[2] & zero));
    chk("branch_target", branch_target_o, btgt);
    @(posedge clk_i);
  endtask

  // Asynchronous reset pulse landing on top of an in-flight store to 0x10.
  task automatic do_reset();
    @(negedge clk_i);
    mon_en       = 1'b0;
    decoder_i    = 5'b00001;
    alu_result_i = 32'h10;
    write_data_i = 32'hBAD0BAD0;
    stall_i      = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_reg_write", 32'(reg_write_o), 32'h0);
    chk("rst_async_mem_to_reg", 32'(mem_to_reg_o), 32'h0);
    chk("rst_async_read_data", read_data_o, 32'h0);
    chk("rst_async_alu_result", alu_result_o, 32'h0);
    chk("rst_async_write_reg", 32'(write_reg_o), 32'h0);
    chk("rst_async_access_err", 32'(access_err_o), 32'h0);
    @(posedge clk_i);
    @(posedge clk_i);
    #1;
    chk("rst_hold_read_data", read_data_o, 32'h0);
    chk("rst_hold_alu_result", alu_result_o, 32'h0);
    chk("rst_hold_access_err", 32'(access_err_o), 32'h0);
    @(negedge clk_i);
    decoder_i = 5'd0;
    stall_i   = 1'b1;
    rst_n     = 1'b1;
    m_wb = '{rw: 1'b0, m2r: 1'b0, rd: 32'h0, alu: 32'h0, wr: 5'd0, err: 1'b0, rd_care: 1'b1};
  endtask

  task automatic rand_issue();
    logic [31:0] addr;
    int sel;
    sel = int'($urandom_range(0, 9));
    if (sel <= 6)      addr = 32'($urandom_range(0, 15)) * 4;
    else if (sel == 7) addr = 32'($urandom_range(0, 15)) * 4 + 32'($urandom_range(1, 3));
    else if (sel == 8) addr = (32'($urandom) & 32'hFFFF_FFFC) | 32'h200;
    else               addr = $urandom;
    issue(5'($urandom), addr, $urandom, 5'($urandom), 1'($urandom),
          $urandom, ($urandom_range(0, 3) == 0));
  endtask

  // Scoreboard monitor: one prediction per clock edge while the pipe is live.
  initial begin
    forever begin
      @(posedge clk_i);
      #1;
      if (mon_en) begin
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL sb_underflow actual=empty required=entry at %0t", $time);
        end else begin
          mon_e = q.pop_front();
          chk("wb_reg_write", 32'(reg_write_o), 32'(mon_e.rw));
          chk("wb_mem_to_reg", 32'(mem_to_reg_o), 32'(mon_e.m2r));
          chk("wb_alu_result", alu_result_o, mon_e.alu);
          chk("wb_write_reg", 32'(write_reg_o), 32'(mon_e.wr));
          chk("wb_access_err", 32'(access_err_o), 32'(mon_e.err));
          if (mon_e.rd_care) chk("wb_read_data", read_data_o, mon_e.rd);
        end
      end
    end
  end

  initial begin
    m_wb = '{rw: 1'b0, m2r: 1'b0, rd: 32'h0, alu: 32'h0, wr: 5'd0, err: 1'b0, rd_care: 1'b1};
    do_reset();

    // Store / load round trip.
    issue(5'b00001, 32'h0,  32'h0BADF00D, 5'd0, 1'b0, 32'h0, 1'b0);
    issue(5'b00001, 32'h10, 32'hDEADBEEF, 5'd0, 1'b0, 32'h0, 1'b0);
    issue(5'b11010, 32'h10, 32'h0,        5'd7, 1'b0, 32'h0, 1'b0);
    #2;
    chk("ld_read_data", read_data_o, 32'hDEADBEEF);
    chk("ld_write_reg", 32'(write_reg_o), 32'd7);
    chk("ld_reg_write", 32'(reg_write_o), 32'h1);
    chk("ld_mem_to_reg", 32'(mem_to_reg_o), 32'h1);

    // Branch taken / not taken.
    issue(5'b00100, 32'h0, 32'h0, 5'd0, 1'b1, 32'h40, 1'b0);
    #2;
    chk("br_taken", 32'(pc_src_o), 32'h1);
    chk("br_target", branch_target_o, 32'h40);
    issue(5'b00100, 32'h0, 32'h0, 5'd0, 1'b0, 32'h40, 1'b0);
    #2;
    chk("br_not_taken", 32'(pc_src_o), 32'h0);
    chk("err_clean", 32'(access_err_o), 32'h0);

    // Misaligned store must not touch 0x10.
    issue(5'b00001, 32'h12, 32'h1234, 5'd0, 1'b0, 32'h0, 1'b0);
    #2;
    chk("mis_err", 32'(access_err_o), 32'h1);
    issue(5'b11010, 32'h10, 32'h0, 5'd8, 1'b0, 32'h0, 1'b0);
    #2;
    chk("mis_keep", read_data_o, 32'hDEADBEEF);

    // Out-of-range load returns zero and does not alias word 0.
    issue(5'b11010, 32'h200, 32'h0, 5'd9, 1'b0, 32'h0, 1'b0);
    #2;
    chk("oor_read_data", read_data_o, 32'h0);
    chk("oor_err", 32'(access_err_o), 32'h1);
    issue(5'b11010, 32'h0, 32'h0, 5'd10, 1'b0, 32'h0, 1'b0);
    #2;
    chk("oor_word0", read_data_o, 32'h0BADF00D);

    // Stalled store is held, then performed once on release.
    for (int i = 0; i < 3; i++) begin
      issue(5'b00001, 32'h8, 32'hA5A5A5A5, 5'd0, 1'b0, 32'h0, 1'b1);
      #2;
      chk("stall_frozen_alu", alu_result_o, 32'h0);
      chk("stall_frozen_wr", 32'(write_reg_o), 32'd10);
    end
    issue(5'b00001, 32'h8, 32'hA5A5A5A5, 5'd0, 1'b0, 32'h0, 1'b0);
    issue(5'b11010, 32'h8, 32'h0, 5'd11, 1'b0, 32'h0, 1'b0);
    #2;
    chk("stall_load", read_data_o, 32'hA5A5A5A5);

    // R-type pass-through, then reset recovery (reset also cancels a store).
    issue(5'b10000, 32'h7, 32'h0, 5'd3, 1'b0, 32'h0, 1'b0);
    #2;
    chk("rtype_alu", alu_result_o, 32'h7);
    chk("rtype_wr", 32'(write_reg_o), 32'd3);
    chk("rtype_rw", 32'(reg_write_o), 32'h1);
    do_reset();
    issue(5'b11010, 32'h10, 32'h0, 5'd12, 1'b0, 32'h0, 1'b0);
    #2;
    chk("rst_store_blocked", read_data_o, 32'hDEADBEEF);
    chk("rst_err_cleared", 32'(access_err_o), 32'h0);

    // Randomized traffic, with a reset in between.
    for (int i = 0; i < 200; i++) rand_issue();
    do_reset();
    for (int i = 0; i < 200; i++) rand_issue();

    #2;
    chk("sb_drain", 32'(q.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard stop if something wedges the stimulus.
  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
